// File: rtl/apb_master_if.sv
// APB bus between apb_master and up to four peripheral slaves.
// Address, control and write data are shared; each slave has its own select, read data and ready.
interface apb_master_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic        PSEL0;
    logic        PSEL1;
    logic        PSEL2;
    logic        PSEL3;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;

    modport master (
        output PADDR, PWRITE, PWDATA, PENABLE,
        output PSEL0, PSEL1, PSEL2, PSEL3,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3
    );

    modport slave (
        input  PADDR, PWRITE, PWDATA, PENABLE,
        input  PSEL0, PSEL1, PSEL2, PSEL3,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3
    );
endinterface

// File: rtl/apb_master.sv
// Single-master APB bridge: one core load/store at a time, four-way address decode,
// registered read data with a one-cycle ready/err pulse and a PREADY watchdog.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] paddr_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [7:0]  wdog;

    logic        hit;
    logic [1:0]  sel;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic [3:0]  psel;

    logic        load;
    logic        done;
    logic        fail;

    // Decode from the latched address so selects stay stable for the whole transfer.
    assign hit = (paddr_q[31:14] == 18'h04000);
    assign sel = paddr_q[13:12];

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise the
        // missing branches would infer latches.
        sel_ready = 1'b0;
        sel_rdata = '0;
        unique case (sel)
            2'd0: begin sel_ready = bus.PREADY0; sel_rdata = bus.PRDATA0; end
            2'd1: begin sel_ready = bus.PREADY1; sel_rdata = bus.PRDATA1; end
            2'd2: begin sel_ready = bus.PREADY2; sel_rdata = bus.PRDATA2; end
            2'd3: begin sel_ready = bus.PREADY3; sel_rdata = bus.PRDATA3; end
            default: begin sel_ready = 1'b0; sel_rdata = '0; end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge values, independent of statement order.
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        done       = 1'b0;
        fail       = 1'b0;
        unique case (state)
            IDLE: begin
                if (transfer) begin
                    load       = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                // A decode miss completes at once; a late PREADY beats the watchdog.
                if (!hit) begin
                    done = 1'b1;
                    fail = 1'b1;
                end else if (sel_ready) begin
                    done = 1'b1;
                end else if (wdog == WDOG_LAST) begin
                    done = 1'b1;
                    fail = 1'b1;
                end
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else if (load) begin
            paddr_q  <= addr;
            pwrite_q <= write;
            pwdata_q <= wdata;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wdog <= '0;
        end else if (state == SETUP) begin
            wdog <= '0;
        end else if (state == ACCESS && !done) begin
            wdog <= wdog + 8'd1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= done;
            err   <= done && fail;
            if (done) begin
                if (fail) begin
                    rdata <= '0;
                end else if (!pwrite_q) begin
                    rdata <= sel_rdata;
                end
            end
        end
    end

    // Selects follow the state register directly so an asynchronous reset drops them at once.
    assign psel = (state != IDLE && hit) ? (4'b0001 << sel) : 4'b0000;

    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PENABLE = (state == ACCESS);
    assign bus.PSEL0   = psel[0];
    assign bus.PSEL1   = psel[1];
    assign bus.PSEL2   = psel[2];
    assign bus.PSEL3   = psel[3];

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table of transfers against a behavioural slave,
// a scoreboard of expected ready pulses, and hand-written back-to-back/reset sequences.
module tb_apb_master;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          wt;      // ACCESS cycles before the selected slave raises PREADY; -1 = never
        int          lat;     // cycles from transfer to ready
        logic [3:0]  psel;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        e;
        int          at;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        transfer = 1'b0;
    logic        write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    apb_master_if bus ();

    apb_master #(.TIMEOUT(TIMEOUT)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .bus      (bus)
    );

    always #5 PCLK = ~PCLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wait_cfg = -1;
    int acc_k = 0;
    exp_t sb[$];
    vec_t vecs[10];
    logic [3:0] psel;

    assign psel = {bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: the selected slave answers after wait_cfg ACCESS cycles; every
    // unselected slave, and any slave outside ACCESS, holds PREADY high to prove it is ignored.
    always @(negedge PCLK) begin
        acc_k <= bus.PENABLE ? acc_k + 1 : 0;
        bus.PREADY0 <= (bus.PSEL0 && bus.PENABLE) ? (acc_k == wait_cfg) : 1'b1;
        bus.PREADY1 <= (bus.PSEL1 && bus.PENABLE) ? (acc_k == wait_cfg) : 1'b1;
        bus.PREADY2 <= (bus.PSEL2 && bus.PENABLE) ? (acc_k == wait_cfg) : 1'b1;
        bus.PREADY3 <= (bus.PSEL3 && bus.PENABLE) ? (acc_k == wait_cfg) : 1'b1;
    end

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    always @(negedge PCLK) begin : mon
        exp_t e;
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rdata", rdata, e.rd);
                check("err", 32'(err), 32'(e.e));
                check("ready_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic drain();
        #1;
        for (int b = 0; b < 40 && sb.size() != 0; b++) @(negedge PCLK);
        if (sb.size() != 0) begin
            check("ready_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge PCLK);
        transfer = 1'b1;
        write    = v.wr;
        addr     = v.a;
        wdata    = v.wd;
        wait_cfg = v.wt;
        sb.push_back('{v.exp_rd, v.exp_err, cyc + v.lat});
        @(negedge PCLK);
        transfer = 1'b0;
        addr     = '1;
        wdata    = '1;
        write    = ~v.wr;
        check("paddr", bus.PADDR, v.a);
        check("pwdata", bus.PWDATA, v.wd);
        check("pwrite", 32'(bus.PWRITE), 32'(v.wr));
        for (int k = 1; k < v.lat; k++) begin
            check("psel", 32'(psel), 32'(v.psel));
            check("penable", 32'(bus.PENABLE), (k >= 2) ? 32'd1 : 32'd0);
            @(negedge PCLK);
        end
        drain();
        @(negedge PCLK);
        check("rdata_held", rdata, v.exp_rd);
        check("ready_low", 32'(ready), 32'd0);
    endtask

    initial begin
        bus.PRDATA0 = 32'h1111_0000;
        bus.PRDATA1 = 32'h2222_0001;
        bus.PRDATA2 = 32'hA5A5_0003;
        bus.PRDATA3 = 32'h4444_0003;

        //            wr    addr           wdata          wt  lat psel     exp_rd         err
        vecs[0] = '{1'b1, 32'h1000_0000, 32'h0000_000F,  1,  4, 4'b0001, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h1000_2004, 32'h0000_0000,  0,  3, 4'b0100, 32'hA5A5_0003, 1'b0};
        vecs[2] = '{1'b0, 32'h2000_0000, 32'h0000_0000,  0,  3, 4'b0000, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 32'h1000_1000, 32'h0000_0000, -1, 18, 4'b0010, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 32'h1000_1000, 32'h0000_0000, 15, 18, 4'b0010, 32'h2222_0001, 1'b0};
        vecs[5] = '{1'b1, 32'h1000_3010, 32'hDEAD_BEEF,  2,  5, 4'b1000, 32'h2222_0001, 1'b0};
        vecs[6] = '{1'b0, 32'h1000_3000, 32'h0000_0000,  0,  3, 4'b1000, 32'h4444_0003, 1'b0};
        vecs[7] = '{1'b0, 32'h1000_1FFC, 32'h0000_0000, 14, 17, 4'b0010, 32'h2222_0001, 1'b0};
        vecs[8] = '{1'b0, 32'h1000_4000, 32'h0000_0000,  0,  3, 4'b0000, 32'h0000_0000, 1'b1};
        vecs[9] = '{1'b0, 32'h0FFF_F000, 32'h0000_0000,  0,  3, 4'b0000, 32'h0000_0000, 1'b1};

        #12;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_paddr", bus.PADDR, 32'd0);
        check("rst_pwdata", bus.PWDATA, 32'd0);
        check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        check("rst_penable", 32'(bus.PENABLE), 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Back-to-back: second request in the ready cycle of the first.
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2004; wait_cfg = 0;
        sb.push_back('{32'hA5A5_0003, 1'b0, cyc + 3});
        @(negedge PCLK);
        transfer = 1'b0;
        repeat (2) @(negedge PCLK);
        transfer = 1'b1; addr = 32'h1000_3000;
        sb.push_back('{32'h4444_0003, 1'b0, cyc + 3});
        @(negedge PCLK);
        transfer = 1'b0;
        check("b2b_setup_psel", 32'(psel), 32'h8);
        check("b2b_setup_penable", 32'(bus.PENABLE), 32'd0);
        drain();

        // A request during ACCESS is dropped: one ready, no restart, PADDR unchanged.
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000; wait_cfg = 3;
        sb.push_back('{32'h2222_0001, 1'b0, cyc + 6});
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000;
        @(negedge PCLK);
        transfer = 1'b0;
        drain();
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            check("no_restart_psel", 32'(psel), 32'd0);
        end
        check("paddr_kept", bus.PADDR, 32'h1000_1000);

        // Reset during ACCESS: selects drop immediately and no ready follows.
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_0000; wait_cfg = -1;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        check("pre_reset_penable", 32'(bus.PENABLE), 32'd1);
        check("pre_reset_psel", 32'(psel), 32'd1);
        #2 PRESET = 1'b1;
        #1;
        check("reset_psel", 32'(psel), 32'd0);
        check("reset_penable", 32'(bus.PENABLE), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (ready !== 1'b0) check("no_ready_after_reset", 32'(ready), 32'd0);
        end
        check("reset_rdata", rdata, 32'd0);
        run_vec('{1'b0, 32'h1000_2008, 32'h0, 0, 3, 4'b0100, 32'hA5A5_0003, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/apb_master.md
# apb_master

Single-master APB bridge between the RISC-V core data bus and the peripheral APB slaves, including GPIO_Periph. It accepts one core load/store request at a time and runs a standard APB SETUP/ACCESS transfer. It decodes the address into one of four PSEL lines, multiplexes PRDATA/PREADY back, and returns read data with a one-cycle completion pulse. A watchdog ends transfers to slaves that never assert PREADY.

## Interface
- TIMEOUT, 16: ACCESS cycles allowed without PREADY before the transfer is aborted with err; range 2..255.
- PCLK  input  1  APB clock; all state on rising edge.
- PRESET  input  1  reset, asynchronous, active-high.
- transfer  input  1  core request pulse; sampled only in IDLE.
- write  input  1  1 = store, 0 = load; sampled with transfer.
- addr  input  32  byte address; sampled with transfer.
- wdata  input  32  store data; sampled with transfer.
- rdata  output  32  load data; valid while ready=1, then held.
- ready  output  1  one-cycle completion pulse.
- err  output  1  qualifies ready; 1 = decode miss or timeout.
- PADDR  output  32  latched addr.
- PWRITE  output  1  latched write.
- PWDATA  output  32  latched wdata.
- PENABLE  output  1  high in ACCESS only.
- PSEL0..PSEL3  output  1 each  slave selects, one-hot or all zero.
- PRDATA0..PRDATA3  input  32 each  slave read data.
- PREADY0..PREADY3  input  1 each  slave ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: when transfer=1, latch addr/write/wdata into PADDR/PWRITE/PWDATA, decode, go to SETUP. When transfer=0, stay in IDLE; PSEL and PENABLE are 0, and PADDR/PWRITE/PWDATA hold their last values.
- SETUP: the decoded PSELn=1 and PENABLE=0. Always go to ACCESS after one cycle.
- ACCESS: PSELn=1 and PENABLE=1. Sample only the selected PREADYn.
  - If PREADYn=1: register rdata <= PRDATAn on a read, or leave rdata unchanged on a write; pulse ready=1 with err=0 next cycle; go to IDLE.
- Decode uses PADDR[31:12]: 0x10000 gives PSEL0, 0x10001 gives PSEL1, 0x10002 gives PSEL2, 0x10003 gives PSEL3.
- Decode miss (any other address):
  - SETUP and ACCESS still run, each for one cycle, with all PSEL at 0.
  - ACCESS treats the transfer as ready. Result: ready=1, err=1, rdata=0.
- Watchdog:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADYn=0.
  - When the counter reaches TIMEOUT-1 with PREADYn still 0: go to IDLE, pulse ready=1, err=1, rdata=0.
- A PREADY arriving in the same cycle the counter reaches TIMEOUT-1 wins: the transfer completes normally with err=0.
- PREADY inputs are ignored outside ACCESS. Unselected PRDATA/PREADY never affect outputs.
- transfer pulses received while not in IDLE are dropped; no queueing.
- In the ready cycle the FSM is already in IDLE. A transfer in that same cycle is accepted, giving back-to-back operation.

## Timing
- Reset values: state IDLE; PADDR, PWDATA, rdata = 0; PWRITE, PENABLE, PSEL0..3, ready, err = 0; watchdog counter = 0.
- Asserting PRESET mid-transfer drops PSEL/PENABLE immediately (asynchronous). No ready pulse is produced for the aborted transfer.
- Latency: transfer at cycle 0, SETUP at cycle 1, first ACCESS at cycle 2.
  - Zero-wait slave (PREADY=1 at cycle 2): ready at cycle 3.
  - Slave with registered PREADY, such as GPIO_Periph (PREADY=1 at cycle 3): ready at cycle 4.
- Decode miss: ready+err at cycle 3.
- Timeout: ready+err at cycle 2+TIMEOUT.
- PADDR, PWRITE, PWDATA and PSELn are stable from SETUP through the last ACCESS cycle.
- ready, err and rdata are registered outputs, never combinational from slave inputs.

## Test plan
- Write 0x0000000F to addr 0x10000000, slave 0 with registered PREADY -> PSEL0=1 cycles 1-3, PENABLE=1 cycles 2-3, PWDATA=0xF, ready=1/err=0 at cycle 4.
- Read addr 0x10002004 with PRDATA2=0xA5A5_0003 and zero-wait PREADY2 -> PSEL2 only, ready at cycle 3, rdata=0xA5A50003, err=0; rdata holds afterwards.
- Read addr 0x20000000 -> all PSEL=0, ready=1/err=1/rdata=0 at cycle 3.
- TIMEOUT=16 with PREADY1 tied 0, read 0x10001000 -> ACCESS held cycles 2-17, ready=1/err=1 at cycle 18, then FSM in IDLE. Repeat with PREADY1=1 at the final ACCESS cycle -> err=0.
- Back-to-back: second transfer pulse in the ready cycle of the first -> new SETUP the next cycle. A pulse during ACCESS -> ignored, with no extra ready.
- PRESET asserted during ACCESS -> PSEL/PENABLE=0 within the same cycle, no ready. After release, a fresh transfer completes normally.
